// File: rtl/drive_cmd_sequencer.sv
// Motor drive command sequencer: one-hot direction output with dead time between motion changes.
// Optional watchdog compiled in with macro WATCHDOG_EN.
`timescale 1ns/1ps
module drive_cmd_sequencer #(
    parameter int unsigned DEADTIME_CYCLES = 12500,
    parameter int unsigned TIMEOUT_CYCLES  = 62500000
) (
    input  logic       clk_125mhz,
    input  logic       reset_n,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_code,
    output logic       cmd_ready,
    output logic [4:0] direction,
    output logic       dead_active,
    output logic       cmd_err,
    output logic       wdt_trip
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DEAD = 2'd2
    } state_e;

    localparam logic [4:0] DIR_FWD   = 5'b00001;
    localparam logic [4:0] DIR_IDLE  = 5'b00010;
    localparam logic [4:0] DIR_BWD   = 5'b00100;
    localparam logic [4:0] DIR_LEFT  = 5'b01000;
    localparam logic [4:0] DIR_RIGHT = 5'b10000;

    localparam int unsigned DEAD_W = 20;
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEADTIME_CYCLES - 1);

    function automatic logic [4:0] code_to_dir(input logic [2:0] code);
        logic [4:0] dir;
        case (code)
            3'd1:    dir = DIR_FWD;
            3'd2:    dir = DIR_BWD;
            3'd3:    dir = DIR_LEFT;
            3'd4:    dir = DIR_RIGHT;
            default: dir = DIR_IDLE;
        endcase
        return dir;
    endfunction

    function automatic logic is_motion(input logic [2:0] code);
        return (code >= 3'd1) && (code <= 3'd4);
    endfunction

    state_e            state_q, state_d;
    logic [4:0]        direction_q, direction_d;
    logic [2:0]        pending_q, pending_d;
    logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              dead_active_q, dead_active_d;
    logic              cmd_err_q, cmd_err_d;
    logic              wdt_trip_q, wdt_trip_d;
    logic              accept_s;
    logic              wdt_expire_s;

    assign accept_s = cmd_valid && cmd_ready_q;

`ifdef WATCHDOG_EN
    localparam int unsigned WDT_W = 27;
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(TIMEOUT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_q, wdt_d;

    assign wdt_expire_s = (wdt_q == WDT_LAST);

    // Watchdog next value: counts only while staying in S_RUN without a new command
    always_comb begin
        wdt_d = wdt_q;
        if (accept_s || (state_q != S_RUN) || (state_d != S_RUN)) begin
            wdt_d = '0;
        end else begin
            wdt_d = wdt_q + WDT_W'(1);
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk_125mhz or negedge reset_n) begin
        if (!reset_n) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end
`else
    assign wdt_expire_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_125mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, pending command and dead-time counter
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        dead_cnt_d = dead_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s && is_motion(cmd_code)) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (accept_s) begin
                    if (!is_motion(cmd_code)) begin
                        state_d = S_IDLE;
                    end else if (code_to_dir(cmd_code) == direction_q) begin
                        state_d = S_RUN;
                    end else begin
                        state_d    = S_DEAD;
                        pending_d  = cmd_code;
                        dead_cnt_d = DEAD_LOAD;
                    end
                end else if (wdt_expire_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DEAD: begin
                if (dead_cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    dead_cnt_d = dead_cnt_q - DEAD_W'(1);
                end
            end
            default: begin
                state_d    = S_IDLE;
                pending_d  = 3'd0;
                dead_cnt_d = '0;
            end
        endcase
    end

    // Output next values, derived from the transition being taken
    always_comb begin
        direction_d   = DIR_IDLE;
        cmd_ready_d   = (state_d != S_DEAD);
        dead_active_d = (state_d == S_DEAD);
        cmd_err_d     = accept_s && (cmd_code > 3'd4);
        wdt_trip_d    = (state_q == S_RUN) && !accept_s && wdt_expire_s;
        case (state_d)
            S_RUN: begin
                if (state_q == S_DEAD) begin
                    direction_d = code_to_dir(pending_q);
                end else if (accept_s) begin
                    direction_d = code_to_dir(cmd_code);
                end else begin
                    direction_d = direction_q;
                end
            end
            S_IDLE:  direction_d = DIR_IDLE;
            S_DEAD:  direction_d = DIR_IDLE;
            default: direction_d = DIR_IDLE;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge clk_125mhz or negedge reset_n) begin
        if (!reset_n) begin
            direction_q   <= DIR_IDLE;
            pending_q     <= 3'd0;
            dead_cnt_q    <= '0;
            cmd_ready_q   <= 1'b1;
            dead_active_q <= 1'b0;
            cmd_err_q     <= 1'b0;
            wdt_trip_q    <= 1'b0;
        end else begin
            direction_q   <= direction_d;
            pending_q     <= pending_d;
            dead_cnt_q    <= dead_cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            dead_active_q <= dead_active_d;
            cmd_err_q     <= cmd_err_d;
            wdt_trip_q    <= wdt_trip_d;
        end
    end

    assign direction   = direction_q;
    assign cmd_ready   = cmd_ready_q;
    assign dead_active = dead_active_q;
    assign cmd_err     = cmd_err_q;
    assign wdt_trip    = wdt_trip_q;

endmodule

// File: tb/tb_drive_cmd_sequencer.sv
// Directed testbench for drive_cmd_sequencer (DEADTIME_CYCLES=4, TIMEOUT_CYCLES=20).
`timescale 1ns/1ps
module tb_drive_cmd_sequencer;

    logic       clk_125mhz = 1'b0;
    logic       reset_n    = 1'b0;
    logic       cmd_valid  = 1'b0;
    logic [2:0] cmd_code   = 3'd0;
    logic       cmd_ready;
    logic [4:0] direction;
    logic       dead_active;
    logic       cmd_err;
    logic       wdt_trip;

    int pass_cnt  = 0;
    int total_cnt = 0;

    drive_cmd_sequencer #(
        .DEADTIME_CYCLES(4),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk_125mhz (clk_125mhz),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .cmd_ready  (cmd_ready),
        .direction  (direction),
        .dead_active(dead_active),
        .cmd_err    (cmd_err),
        .wdt_trip   (wdt_trip)
    );

    always #4 clk_125mhz = ~clk_125mhz;

    task automatic tick();
        @(posedge clk_125mhz);
        #1;
    endtask

    task automatic send(input logic [2:0] c);
        cmd_valid = 1'b1;
        cmd_code  = c;
        tick();
        cmd_valid = 1'b0;
        cmd_code  = 3'd0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        total_cnt++;
        if ({direction, cmd_ready, dead_active, cmd_err, wdt_trip} !== {5'b00010, 1'b1, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_state: got dir=%b rdy=%b dead=%b err=%b wdt=%b want 00010 1 0 0 0",
                     direction, cmd_ready, dead_active, cmd_err, wdt_trip);
        else pass_cnt++;
        reset_n = 1'b1;
        tick();
        total_cnt++;
        if (direction !== 5'b00010) $display("FAIL reset_release_dir: got %b want 00010", direction);
        else pass_cnt++;
    endtask

    task automatic test_forward();
        send(3'd1);
        total_cnt++;
        if (direction !== 5'b00001) $display("FAIL fwd_dir: got %b want 00001", direction);
        else pass_cnt++;
        total_cnt++;
        if ({cmd_ready, dead_active} !== 2'b10) $display("FAIL fwd_ready: got rdy/dead=%b want 10", {cmd_ready, dead_active});
        else pass_cnt++;
    endtask

    task automatic test_deadtime();
        send(3'd2);
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if ({direction, dead_active, cmd_ready} !== {5'b00010, 1'b1, 1'b0})
                $display("FAIL dead_cycle%0d: got dir=%b dead=%b rdy=%b want 00010 1 0", i, direction, dead_active, cmd_ready);
            else pass_cnt++;
            // commands offered while dead time runs must be ignored
            if (i < 3) begin
                cmd_valid = 1'b1;
                cmd_code  = 3'd4;
            end else begin
                cmd_valid = 1'b0;
                cmd_code  = 3'd0;
            end
            tick();
        end
        total_cnt++;
        if ({direction, dead_active, cmd_ready} !== {5'b00100, 1'b0, 1'b1})
            $display("FAIL dead_end: got dir=%b dead=%b rdy=%b want 00100 0 1", direction, dead_active, cmd_ready);
        else pass_cnt++;
    endtask

    task automatic test_invalid();
        send(3'd4);
        repeat (4) tick();
        total_cnt++;
        if (direction !== 5'b10000) $display("FAIL right_dir: got %b want 10000", direction);
        else pass_cnt++;
        send(3'd6);
        total_cnt++;
        if ({direction, cmd_err, dead_active, cmd_ready} !== {5'b00010, 1'b1, 1'b0, 1'b1})
            $display("FAIL inv_run: got dir=%b err=%b dead=%b rdy=%b want 00010 1 0 1", direction, cmd_err, dead_active, cmd_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({direction, cmd_err} !== {5'b00010, 1'b0}) $display("FAIL inv_pulse: got dir=%b err=%b want 00010 0", direction, cmd_err);
        else pass_cnt++;
        send(3'd1);
        total_cnt++;
        if ({direction, dead_active} !== {5'b00001, 1'b0}) $display("FAIL idle_to_fwd: got dir=%b dead=%b want 00001 0", direction, dead_active);
        else pass_cnt++;
        send(3'd0);
        total_cnt++;
        if ({direction, dead_active} !== {5'b00010, 1'b0}) $display("FAIL run_stop: got dir=%b dead=%b want 00010 0", direction, dead_active);
        else pass_cnt++;
        send(3'd7);
        total_cnt++;
        if ({direction, cmd_err} !== {5'b00010, 1'b1}) $display("FAIL inv_idle: got dir=%b err=%b want 00010 1", direction, cmd_err);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (cmd_err !== 1'b0) $display("FAIL inv_idle_pulse: got %b want 0", cmd_err);
        else pass_cnt++;
    endtask

    task automatic test_same_code();
        send(3'd1);
        send(3'd1);
        total_cnt++;
        if ({direction, dead_active, cmd_ready} !== {5'b00001, 1'b0, 1'b1})
            $display("FAIL same_code: got dir=%b dead=%b rdy=%b want 00001 0 1", direction, dead_active, cmd_ready);
        else pass_cnt++;
        send(3'd0);
    endtask

`ifdef WATCHDOG_EN
    task automatic test_watchdog();
        logic seen;
        send(3'd3);
        repeat (19) tick();
        total_cnt++;
        if ({direction, wdt_trip} !== {5'b01000, 1'b0}) $display("FAIL wdt_before: got dir=%b wdt=%b want 01000 0", direction, wdt_trip);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({direction, wdt_trip} !== {5'b00010, 1'b1}) $display("FAIL wdt_trip: got dir=%b wdt=%b want 00010 1", direction, wdt_trip);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({direction, wdt_trip} !== {5'b00010, 1'b0}) $display("FAIL wdt_pulse: got dir=%b wdt=%b want 00010 0", direction, wdt_trip);
        else pass_cnt++;

        send(3'd3);
        seen = 1'b0;
        for (int cyc = 1; cyc < 60; cyc++) begin
            cmd_valid = (cyc % 10 == 0);
            cmd_code  = 3'd3;
            tick();
            if (wdt_trip === 1'b1) seen = 1'b1;
        end
        cmd_valid = 1'b0;
        total_cnt++;
        if ({seen, direction} !== {1'b0, 5'b01000}) $display("FAIL wdt_keepalive: got trip_seen=%b dir=%b want 0 01000", seen, direction);
        else pass_cnt++;

        send(3'd0);
        send(3'd3);
        repeat (19) tick();
        send(3'd3);
        total_cnt++;
        if ({direction, wdt_trip} !== {5'b01000, 1'b0}) $display("FAIL wdt_priority: got dir=%b wdt=%b want 01000 0", direction, wdt_trip);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({direction, wdt_trip} !== {5'b01000, 1'b0}) $display("FAIL wdt_priority_next: got dir=%b wdt=%b want 01000 0", direction, wdt_trip);
        else pass_cnt++;
        send(3'd0);
    endtask
`else
    task automatic test_no_watchdog();
        logic seen;
        send(3'd1);
        seen = 1'b0;
        repeat (100) begin
            tick();
            if (wdt_trip !== 1'b0) seen = 1'b1;
        end
        total_cnt++;
        if ({direction, seen} !== {5'b00001, 1'b0}) $display("FAIL no_wdt: got dir=%b trip_seen=%b want 00001 0", direction, seen);
        else pass_cnt++;
        send(3'd0);
    endtask
`endif

    task automatic test_reset_in_dead();
        send(3'd1);
        send(3'd2);
        tick();
        #1;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({direction, dead_active, cmd_ready} !== {5'b00010, 1'b0, 1'b1})
            $display("FAIL async_reset: got dir=%b dead=%b rdy=%b want 00010 0 1", direction, dead_active, cmd_ready);
        else pass_cnt++;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (6) tick();
        total_cnt++;
        if ({direction, dead_active} !== {5'b00010, 1'b0}) $display("FAIL reset_discard: got dir=%b dead=%b want 00010 0", direction, dead_active);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_deadtime();
        test_invalid();
        test_same_code();
`ifdef WATCHDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        test_reset_in_dead();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
